axis_chn_router: RTL and testbench
==================================

Name: axis_chn_router

Overview:
- Parametrised successor of the 2-channel AXIS rx/tx channel selector, scaled to CHN_NUM channels.
- Routes one of CHN_NUM rx AXI-Stream inputs to a single downstream consumer (DDC side).
- Routes one upstream producer (DUC side) to one of CHN_NUM tx AXI-Stream outputs.
- Channel switches take effect only on packet boundaries. Adds per-direction packet counters and a configurable LED pulse, all controlled via the local bus.

Parameters:
U_DLY, 1, simulation register delay
CHN_NUM, 4, rx and tx channel count, 2..16; SW = clog2(CHN_NUM)
DW, 32, stream data width
REG_BASE, 14'd16000, local-bus base address of the register block
LED_LEN, 1000, LED pulse length in clocks, 1..65535
DRAIN_UNSEL, 1, 1: unselected rx tready=1 (data discarded); 0: unselected rx tready=0

Ports:
axis_clk  in  1  single clock for stream and local bus
rst_n  in  1  asynchronous active-low reset
lbs_addr  in  14  local-bus address
lbs_din  in  32  local-bus write data
lbs_we  in  1  write strobe, one beat per cycle high
lbs_re  in  1  read strobe, unused for timing; reads are address-driven
lbs_dout  out  32  registered read data
s_rx_tvalid  in  CHN_NUM  per-channel rx valid
s_rx_tdata  in  CHN_NUM*DW  rx data; channel i at [i*DW +: DW]
s_rx_tlast  in  CHN_NUM  rx last
s_rx_tready  out  CHN_NUM  rx ready
m_rx_tvalid / m_rx_tdata(DW) / m_rx_tlast  out  selected rx stream
m_rx_tready  in  1  downstream ready
s_tx_tvalid / s_tx_tdata(DW) / s_tx_tlast  in  upstream tx stream
s_tx_tready  out  1  upstream ready
m_tx_tvalid  out  CHN_NUM  per-channel tx valid
m_tx_tdata  out  CHN_NUM*DW  tx data, broadcast to all channels
m_tx_tlast  out  CHN_NUM  tx last
m_tx_tready  in  CHN_NUM  per-channel tx ready
led_pulse  out  1  LED pulse

Behaviour:
- Reset state: all registers 0; active rx/tx channel 0; not in packet; counters 0; led_pulse=0; lbs_dout=0.
- Datapaths are combinational (zero latency) from the active channel.
  - rx: m_rx_* = s_rx_*[rx_act]. s_rx_tready[rx_act] = m_rx_tready; all other channels = DRAIN_UNSEL.
  - tx: m_tx_tvalid/tlast[tx_act] = s_tx_*; all other channels 0. s_tx_tready = m_tx_tready[tx_act].
- Register map (offsets from REG_BASE):
  - +0 RX_SEL rw. Write value < CHN_NUM sets rx_req; out-of-range writes are ignored.
  - +1 TX_SEL rw, same rules, sets tx_req.
  - +2 LED wo. Writing 0x5555 sets led_pulse=1 and loads the counter with LED_LEN-1. led_pulse clears on the cycle after the counter reaches 0. A retrigger while the pulse is active reloads the counter.
  - +3 RX_PKT ro: count of rx beats accepted with tlast=1.
  - +4 TX_PKT ro: same, counted on the tx side.
  - +5 STATUS ro: [3:0] rx_act, [7:4] tx_act, [8] rx_in_pkt, [9] tx_in_pkt, [10] rx pending (rx_req != rx_act), [11] tx pending.
  - +6 CLR wo. Writing 0x5555 zeroes both packet counters. A simultaneous increment is lost; the clear wins.
- Reads: lbs_dout registered, 1-cycle latency. Reads of +0/+1 return the requested value. Unmapped addresses return 0.
- Packet tracking per direction:
  - acc = tvalid & tready on the active channel.
  - in_pkt_next = acc ? ~tlast : in_pkt.
  - act <= req whenever in_pkt_next == 0. A select written mid-packet is deferred until the beat carrying tlast is accepted; the switch takes effect the following cycle.
- Counters are 32-bit and saturate at 0xFFFF_FFFF (no wrap).
- Reset mid-packet: the active channel returns to 0 and the partial packet is abandoned with no tlast emitted.

Test Plan:
- Reset, then read +0, +1, +5 → 0, 0, 0. Stream 3 packets of 4 beats on rx ch0 → m_rx carries ch0 data; RX_PKT=3.
- Mid-packet (beat 2 of 8 on ch0) write RX_SEL=2 → STATUS[10]=1; beats 3..8 still come from ch0; ch2 is routed from the cycle after ch0 tlast; STATUS[3:0]=2.
- Write TX_SEL=3, send 1-beat packet → only m_tx_tvalid[3]=1; s_tx_tready follows m_tx_tready[3]; TX_PKT=1. Write TX_SEL=7 (CHN_NUM=4) → ignored, TX_SEL reads 3.
- DRAIN_UNSEL=1: s_rx_tready of unselected channels =1. DRAIN_UNSEL=0: =0, and m_rx_tready=0 stalls only the active channel.
- Write LED 0x5555 with LED_LEN=1000 → led_pulse high exactly 1000 clocks. Retrigger at clock 500 → high for 1500 clocks total.
- Preload RX_PKT to 0xFFFF_FFFF via forced stimulus, send 1 more packet → reads 0xFFFF_FFFF. Write CLR 0x5555 → both counters read 0.

Source files
------------

// File: rtl/axis_chn_router.sv
// CHN_NUM-way AXI-Stream rx/tx channel router with packet-boundary switching,
// per-direction packet counters and a local-bus LED pulse.
module axis_chn_router #(
    parameter int unsigned U_DLY       = 1,
    parameter int unsigned CHN_NUM     = 4,
    parameter int unsigned DW          = 32,
    parameter logic [13:0] REG_BASE    = 14'd16000,
    parameter int unsigned LED_LEN     = 1000,
    parameter bit          DRAIN_UNSEL = 1'b1
) (
    input  logic                   axis_clk,
    input  logic                   rst_n,
    input  logic [13:0]            lbs_addr,
    input  logic [31:0]            lbs_din,
    input  logic                   lbs_we,
    input  logic                   lbs_re,
    output logic [31:0]            lbs_dout,
    input  logic [CHN_NUM-1:0]     s_rx_tvalid,
    input  logic [CHN_NUM*DW-1:0]  s_rx_tdata,
    input  logic [CHN_NUM-1:0]     s_rx_tlast,
    output logic [CHN_NUM-1:0]     s_rx_tready,
    output logic                   m_rx_tvalid,
    output logic [DW-1:0]          m_rx_tdata,
    output logic                   m_rx_tlast,
    input  logic                   m_rx_tready,
    input  logic                   s_tx_tvalid,
    input  logic [DW-1:0]          s_tx_tdata,
    input  logic                   s_tx_tlast,
    output logic                   s_tx_tready,
    output logic [CHN_NUM-1:0]     m_tx_tvalid,
    output logic [CHN_NUM*DW-1:0]  m_tx_tdata,
    output logic [CHN_NUM-1:0]     m_tx_tlast,
    input  logic [CHN_NUM-1:0]     m_tx_tready,
    output logic                   led_pulse
);

    localparam int unsigned SW = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;

    localparam logic [13:0] ADDR_RX_SEL = REG_BASE;
    localparam logic [13:0] ADDR_TX_SEL = REG_BASE + 14'd1;
    localparam logic [13:0] ADDR_LED    = REG_BASE + 14'd2;
    localparam logic [13:0] ADDR_RX_PKT = REG_BASE + 14'd3;
    localparam logic [13:0] ADDR_TX_PKT = REG_BASE + 14'd4;
    localparam logic [13:0] ADDR_STATUS = REG_BASE + 14'd5;
    localparam logic [13:0] ADDR_CLR    = REG_BASE + 14'd6;

    localparam logic [31:0] MAGIC      = 32'h0000_5555;
    localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;
    localparam logic [15:0] LED_RELOAD = 16'(LED_LEN - 1);

    logic [SW-1:0] rx_req, rx_act, tx_req, tx_act;
    logic          rx_in_pkt, tx_in_pkt;
    logic          rx_acc, tx_acc;
    logic          rx_in_pkt_nxt, tx_in_pkt_nxt;
    logic [31:0]   rx_pkt_cnt, tx_pkt_cnt;
    logic [15:0]   led_cnt;
    logic          wr_rx_sel, wr_tx_sel, wr_led, wr_clr;
    logic [31:0]   rd_data;
    logic [DW-1:0] rx_data_arr [CHN_NUM];

    for (genvar g = 0; g < CHN_NUM; g++) begin : g_rx_unpack
        assign rx_data_arr[g] = s_rx_tdata[g*DW +: DW];
    end

    // rx: active channel straight through; idle channels drain or stall
    always_comb begin
        m_rx_tvalid         = s_rx_tvalid[rx_act];
        m_rx_tlast          = s_rx_tlast[rx_act];
        m_rx_tdata          = rx_data_arr[rx_act];
        s_rx_tready         = {CHN_NUM{DRAIN_UNSEL}};
        s_rx_tready[rx_act] = m_rx_tready;
    end

    // tx: data broadcast, handshake only on the active channel
    always_comb begin
        m_tx_tvalid         = '0;
        m_tx_tlast          = '0;
        m_tx_tvalid[tx_act] = s_tx_tvalid;
        m_tx_tlast[tx_act]  = s_tx_tlast;
        s_tx_tready         = m_tx_tready[tx_act];
    end

    assign m_tx_tdata = {CHN_NUM{s_tx_tdata}};

    assign rx_acc        = s_rx_tvalid[rx_act] & m_rx_tready;
    assign tx_acc        = s_tx_tvalid & m_tx_tready[tx_act];
    assign rx_in_pkt_nxt = rx_acc ? ~s_rx_tlast[rx_act] : rx_in_pkt;
    assign tx_in_pkt_nxt = tx_acc ? ~s_tx_tlast : tx_in_pkt;

    assign wr_rx_sel = lbs_we && (lbs_addr == ADDR_RX_SEL) && (lbs_din < 32'(CHN_NUM));
    assign wr_tx_sel = lbs_we && (lbs_addr == ADDR_TX_SEL) && (lbs_din < 32'(CHN_NUM));
    assign wr_led    = lbs_we && (lbs_addr == ADDR_LED) && (lbs_din == MAGIC);
    assign wr_clr    = lbs_we && (lbs_addr == ADDR_CLR) && (lbs_din == MAGIC);

    // requested selection is adopted only outside a packet
    always_ff @(posedge axis_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_req    <= '0;
            tx_req    <= '0;
            rx_act    <= '0;
            tx_act    <= '0;
            rx_in_pkt <= 1'b0;
            tx_in_pkt <= 1'b0;
        end else begin
            rx_in_pkt <= rx_in_pkt_nxt;
            tx_in_pkt <= tx_in_pkt_nxt;
            if (!rx_in_pkt_nxt) rx_act <= rx_req;
            if (!tx_in_pkt_nxt) tx_act <= tx_req;
            if (wr_rx_sel) rx_req <= SW'(lbs_din);
            if (wr_tx_sel) tx_req <= SW'(lbs_din);
        end
    end

    // saturating packet counters; a clear overrides a same-cycle increment
    always_ff @(posedge axis_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pkt_cnt <= '0;
            tx_pkt_cnt <= '0;
        end else if (wr_clr) begin
            rx_pkt_cnt <= '0;
            tx_pkt_cnt <= '0;
        end else begin
            if (rx_acc && s_rx_tlast[rx_act] && (rx_pkt_cnt != CNT_MAX))
                rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
            if (tx_acc && s_tx_tlast && (tx_pkt_cnt != CNT_MAX))
                tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
        end
    end

    // LED pulse stays high for LED_LEN clocks from the (re)trigger
    always_ff @(posedge axis_clk or negedge rst_n) begin
        if (!rst_n) begin
            led_pulse <= 1'b0;
            led_cnt   <= '0;
        end else if (wr_led) begin
            led_pulse <= 1'b1;
            led_cnt   <= LED_RELOAD;
        end else if (led_pulse) begin
            if (led_cnt == 16'd0) led_pulse <= 1'b0;
            else                  led_cnt   <= led_cnt - 16'd1;
        end
    end

    always_comb begin
        rd_data = '0;
        case (lbs_addr)
            ADDR_RX_SEL: rd_data = 32'(rx_req);
            ADDR_TX_SEL: rd_data = 32'(tx_req);
            ADDR_RX_PKT: rd_data = rx_pkt_cnt;
            ADDR_TX_PKT: rd_data = tx_pkt_cnt;
            ADDR_STATUS: rd_data = {20'd0, (tx_req != tx_act), (rx_req != rx_act),
                                    tx_in_pkt, rx_in_pkt, 4'(tx_act), 4'(rx_act)};
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge axis_clk or negedge rst_n) begin
        if (!rst_n) lbs_dout <= '0;
        else        lbs_dout <= rd_data;
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, lbs_re, 1'(U_DLY)};

endmodule

// File: tb/tb_axis_chn_router.sv
// Randomised self-checking bench for axis_chn_router against a transaction-level model.
module tb_axis_chn_router;

    localparam int unsigned CHN     = 4;
    localparam int unsigned DW      = 32;
    localparam int unsigned LED_LEN = 1000;
    localparam logic [13:0] BASE    = 14'd16000;

    logic              axis_clk, rst_n;
    logic [13:0]       lbs_addr;
    logic [31:0]       lbs_din;
    logic              lbs_we, lbs_re;
    logic [31:0]       lbs_dout, d0_lbs_dout;
    logic [CHN-1:0]    s_rx_tvalid, s_rx_tlast, s_rx_tready, d0_s_rx_tready;
    logic [CHN*DW-1:0] s_rx_tdata;
    logic              m_rx_tvalid, m_rx_tlast, m_rx_tready, d0_m_rx_tvalid, d0_m_rx_tlast;
    logic [DW-1:0]     m_rx_tdata, d0_m_rx_tdata;
    logic              s_tx_tvalid, s_tx_tlast, s_tx_tready, d0_s_tx_tready;
    logic [DW-1:0]     s_tx_tdata;
    logic [CHN-1:0]    m_tx_tvalid, m_tx_tlast, m_tx_tready, d0_m_tx_tvalid, d0_m_tx_tlast;
    logic [CHN*DW-1:0] m_tx_tdata, d0_m_tx_tdata;
    logic              led_pulse, d0_led_pulse;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          rx_act_m, rx_req_m, tx_act_m, tx_req_m;
    bit          rx_inp_m, tx_inp_m;
    logic [31:0] rx_cnt_m, tx_cnt_m;

    axis_chn_router #(.CHN_NUM(CHN), .DW(DW), .REG_BASE(BASE), .LED_LEN(LED_LEN),
                      .DRAIN_UNSEL(1'b1)) dut (
        .axis_clk(axis_clk), .rst_n(rst_n), .lbs_addr(lbs_addr), .lbs_din(lbs_din),
        .lbs_we(lbs_we), .lbs_re(lbs_re), .lbs_dout(lbs_dout),
        .s_rx_tvalid(s_rx_tvalid), .s_rx_tdata(s_rx_tdata), .s_rx_tlast(s_rx_tlast),
        .s_rx_tready(s_rx_tready), .m_rx_tvalid(m_rx_tvalid), .m_rx_tdata(m_rx_tdata),
        .m_rx_tlast(m_rx_tlast), .m_rx_tready(m_rx_tready),
        .s_tx_tvalid(s_tx_tvalid), .s_tx_tdata(s_tx_tdata), .s_tx_tlast(s_tx_tlast),
        .s_tx_tready(s_tx_tready), .m_tx_tvalid(m_tx_tvalid), .m_tx_tdata(m_tx_tdata),
        .m_tx_tlast(m_tx_tlast), .m_tx_tready(m_tx_tready), .led_pulse(led_pulse));

    axis_chn_router #(.CHN_NUM(CHN), .DW(DW), .REG_BASE(BASE), .LED_LEN(LED_LEN),
                      .DRAIN_UNSEL(1'b0)) dut0 (
        .axis_clk(axis_clk), .rst_n(rst_n), .lbs_addr(lbs_addr), .lbs_din(lbs_din),
        .lbs_we(lbs_we), .lbs_re(lbs_re), .lbs_dout(d0_lbs_dout),
        .s_rx_tvalid(s_rx_tvalid), .s_rx_tdata(s_rx_tdata), .s_rx_tlast(s_rx_tlast),
        .s_rx_tready(d0_s_rx_tready), .m_rx_tvalid(d0_m_rx_tvalid), .m_rx_tdata(d0_m_rx_tdata),
        .m_rx_tlast(d0_m_rx_tlast), .m_rx_tready(m_rx_tready),
        .s_tx_tvalid(s_tx_tvalid), .s_tx_tdata(s_tx_tdata), .s_tx_tlast(s_tx_tlast),
        .s_tx_tready(d0_s_tx_tready), .m_tx_tvalid(d0_m_tx_tvalid), .m_tx_tdata(d0_m_tx_tdata),
        .m_tx_tlast(d0_m_tx_tlast), .m_tx_tready(m_tx_tready), .led_pulse(d0_led_pulse));

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic model_reset();
        rx_act_m = 0; rx_req_m = 0; tx_act_m = 0; tx_req_m = 0;
        rx_inp_m = 0; tx_inp_m = 0; rx_cnt_m = '0; tx_cnt_m = '0;
    endtask

    // effect of one clock edge: packets counted, selections adopted between packets
    task automatic model_edge(input bit racc, input bit rlast, input bit tacc, input bit tlast,
                              input bit we, input logic [13:0] addr, input logic [31:0] din);
        if (racc && rlast && rx_cnt_m != 32'hFFFF_FFFF) rx_cnt_m = rx_cnt_m + 1;
        if (tacc && tlast && tx_cnt_m != 32'hFFFF_FFFF) tx_cnt_m = tx_cnt_m + 1;
        if (we && addr == BASE + 14'd6 && din == 32'h5555) begin
            rx_cnt_m = 0;
            tx_cnt_m = 0;
        end
        if (racc) rx_inp_m = !rlast;
        if (tacc) tx_inp_m = !tlast;
        if (!rx_inp_m) rx_act_m = rx_req_m;
        if (!tx_inp_m) tx_act_m = tx_req_m;
        if (we && addr == BASE && din < CHN) rx_req_m = int'(din);
        if (we && addr == BASE + 14'd1 && din < CHN) tx_req_m = int'(din);
    endtask

    function automatic logic [31:0] model_read(input logic [13:0] addr);
        case (addr)
            BASE:          return 32'(rx_req_m);
            BASE + 14'd1:  return 32'(tx_req_m);
            BASE + 14'd3:  return rx_cnt_m;
            BASE + 14'd4:  return tx_cnt_m;
            BASE + 14'd5:  return {20'd0, tx_req_m != tx_act_m, rx_req_m != rx_act_m,
                                   tx_inp_m, rx_inp_m, 4'(tx_act_m), 4'(rx_act_m)};
            default:       return 32'd0;
        endcase
    endfunction

    task automatic lb_write(input logic [13:0] addr, input logic [31:0] data);
        @(negedge axis_clk);
        s_rx_tvalid = '0; s_tx_tvalid = 1'b0;
        lbs_we = 1'b1; lbs_addr = addr; lbs_din = data;
        model_edge(0, 0, 0, 0, 1, addr, data);
        @(posedge axis_clk); #1;
        lbs_we = 1'b0;
    endtask

    task automatic lb_read(input logic [13:0] addr, output logic [31:0] data,
                           output logic [31:0] exp);
        @(negedge axis_clk);
        s_rx_tvalid = '0; s_tx_tvalid = 1'b0;
        lbs_we = 1'b0; lbs_re = 1'b1; lbs_addr = addr;
        exp = model_read(addr);
        model_edge(0, 0, 0, 0, 0, addr, 32'd0);
        @(posedge axis_clk); #1;
        data = lbs_dout;
        lbs_re = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [13:0] addr);
        logic [31:0] rd, exp;
        lb_read(addr, rd, exp);
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, rd, exp);
        end
    endtask

    // one rx clock: drive, check the combinational routing, advance the model
    task automatic cycle_rx(input logic [CHN-1:0] v, input logic [CHN-1:0] l, input logic rdy,
                            input bit we, input logic [13:0] addr, input logic [31:0] din,
                            output bit acc);
        logic [DW-1:0]  d [CHN];
        logic [CHN-1:0] e1, e0;
        @(negedge axis_clk);
        for (int i = 0; i < CHN; i++) begin
            d[i] = $urandom;
            s_rx_tdata[i*DW +: DW] = d[i];
        end
        s_rx_tvalid = v; s_rx_tlast = l; m_rx_tready = rdy; s_tx_tvalid = 1'b0;
        lbs_we = we; lbs_addr = addr; lbs_din = din;
        #1;
        checks++;
        if (m_rx_tvalid !== v[rx_act_m] || m_rx_tlast !== l[rx_act_m] || m_rx_tdata !== d[rx_act_m]) begin
            errors++;
            $display("FAIL rx_route: got v%b l%b d%h expected v%b l%b d%h (ch %0d)", m_rx_tvalid,
                     m_rx_tlast, m_rx_tdata, v[rx_act_m], l[rx_act_m], d[rx_act_m], rx_act_m);
        end
        for (int i = 0; i < CHN; i++) begin
            e1[i] = (i == rx_act_m) ? rdy : 1'b1;
            e0[i] = (i == rx_act_m) ? rdy : 1'b0;
        end
        checks++;
        if (s_rx_tready !== e1) begin
            errors++;
            $display("FAIL rx_ready_drain: got %b expected %b", s_rx_tready, e1);
        end
        checks++;
        if (d0_s_rx_tready !== e0) begin
            errors++;
            $display("FAIL rx_ready_stall: got %b expected %b", d0_s_rx_tready, e0);
        end
        acc = v[rx_act_m] && rdy;
        model_edge(acc, l[rx_act_m], 0, 0, we, addr, din);
    endtask

    task automatic cycle_tx(input logic v, input logic l, input logic [CHN-1:0] rdy,
                            input bit we, input logic [31:0] sel, output bit acc);
        logic [DW-1:0]  d;
        logic [CHN-1:0] ev, el;
        @(negedge axis_clk);
        d = $urandom;
        s_rx_tvalid = '0; s_tx_tvalid = v; s_tx_tlast = l; s_tx_tdata = d; m_tx_tready = rdy;
        lbs_we = we; lbs_addr = BASE + 14'd1; lbs_din = sel;
        #1;
        ev = '0; el = '0;
        ev[tx_act_m] = v; el[tx_act_m] = l;
        checks++;
        if (m_tx_tvalid !== ev || m_tx_tlast !== el || s_tx_tready !== rdy[tx_act_m]) begin
            errors++;
            $display("FAIL tx_route: got v%b l%b r%b expected v%b l%b r%b", m_tx_tvalid,
                     m_tx_tlast, s_tx_tready, ev, el, rdy[tx_act_m]);
        end
        checks++;
        if (m_tx_tdata !== {CHN{d}}) begin
            errors++;
            $display("FAIL tx_bcast: got %h expected %h", m_tx_tdata, {CHN{d}});
        end
        acc = v && rdy[tx_act_m];
        model_edge(0, 0, acc, l, we, BASE + 14'd1, sel);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_rx_tvalid = '0; s_rx_tlast = '0; s_rx_tdata = '0; m_rx_tready = 1'b0;
        s_tx_tvalid = 1'b0; s_tx_tlast = 1'b0; s_tx_tdata = '0; m_tx_tready = '0;
        lbs_we = 1'b0; lbs_re = 1'b0; lbs_addr = '0; lbs_din = '0;
        model_reset();
        repeat (3) @(negedge axis_clk);
        checks++;
        if (led_pulse !== 1'b0 || lbs_dout !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got led %b dout %h expected 0 0", led_pulse, lbs_dout);
        end
        rst_n = 1'b1;
        read_check("reset_rx_sel", BASE);
        read_check("reset_tx_sel", BASE + 14'd1);
        read_check("reset_status", BASE + 14'd5);
        read_check("unmapped", BASE + 14'd9);
    endtask

    task automatic test_rx_packets();
        int b = 0;
        bit acc;
        logic [31:0] rd, exp;
        for (int c = 0; c < 400 && b < 12; c++) begin
            logic [CHN-1:0] v = 4'($urandom);
            logic [CHN-1:0] l = 4'($urandom);
            v[0] = ($urandom % 4) != 0;
            l[0] = (b % 4) == 3;
            cycle_rx(v, l, ($urandom % 4) != 0, 0, BASE, 0, acc);
            if (acc) b++;
        end
        lb_read(BASE + 14'd3, rd, exp);
        checks++;
        if (rd !== 32'd3 || exp !== 32'd3) begin
            errors++;
            $display("FAIL rx_pkt_count: got %h expected %h", rd, 32'd3);
        end
    endtask

    task automatic test_rx_switch();
        bit acc;
        logic [31:0] rd, exp;
        cycle_rx(4'b0101, 4'b0000, 1, 0, BASE, 0, acc);
        cycle_rx(4'b0101, 4'b0000, 1, 1, BASE, 2, acc);
        lb_read(BASE + 14'd5, rd, exp);
        checks++;
        if ((rd & 32'h50F) !== 32'h500 || rd !== exp) begin
            errors++;
            $display("FAIL switch_pending: got %h expected %h", rd, exp);
        end
        for (int b = 2; b < 8; b++)
            cycle_rx(4'b0101, (b == 7) ? 4'b0001 : 4'b0000, 1, 0, BASE, 0, acc);
        cycle_rx(4'b0101, 4'b0100, 1, 0, BASE, 0, acc);
        lb_read(BASE + 14'd5, rd, exp);
        checks++;
        if ((rd & 32'h50F) !== 32'h002 || rd !== exp) begin
            errors++;
            $display("FAIL switch_done: got %h expected %h", rd, exp);
        end
    endtask

    task automatic test_rx_random();
        bit acc;
        for (int c = 0; c < 300; c++) begin
            bit we = ($urandom % 16) == 0;
            cycle_rx(4'($urandom), 4'($urandom) & 4'($urandom), $urandom % 2 == 0, we, BASE,
                     32'($urandom % 8), acc);
        end
        read_check("rx_rand_count", BASE + 14'd3);
        read_check("rx_rand_status", BASE + 14'd5);
        read_check("rx_rand_sel", BASE);
    endtask

    task automatic test_tx();
        bit acc = 0;
        logic [31:0] rd, exp;
        cycle_tx(0, 0, 4'($urandom), 1, 3, acc);
        cycle_tx(0, 0, 4'($urandom), 0, 0, acc);
        acc = 0;
        for (int c = 0; c < 50 && !acc; c++) cycle_tx(1, 1, 4'($urandom), 0, 0, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL tx_timeout: got no accept expected accept within 50 cycles");
        end
        lb_read(BASE + 14'd4, rd, exp);
        checks++;
        if (rd !== 32'd1 || exp !== 32'd1) begin
            errors++;
            $display("FAIL tx_pkt_count: got %h expected %h", rd, 32'd1);
        end
        cycle_tx(0, 0, 4'($urandom), 1, 7, acc);
        lb_read(BASE + 14'd1, rd, exp);
        checks++;
        if (rd !== 32'd3 || exp !== 32'd3) begin
            errors++;
            $display("FAIL tx_sel_oob: got %h expected %h", rd, 32'd3);
        end
        for (int c = 0; c < 300; c++)
            cycle_tx($urandom % 2 == 0, $urandom % 3 == 0, 4'($urandom), ($urandom % 16) == 0,
                     32'($urandom % 8), acc);
        read_check("tx_rand_count", BASE + 14'd4);
        read_check("tx_rand_status", BASE + 14'd5);
    endtask

    task automatic led_run(input string name, input bit retrig, input int expect_len);
        int cnt = 0;
        lb_write(BASE + 14'd2, 32'h5555);
        for (int i = 0; i < 3000; i++) begin
            if (!led_pulse) break;
            cnt++;
            if (retrig && cnt == 500) begin
                lbs_we = 1'b1; lbs_addr = BASE + 14'd2; lbs_din = 32'h5555;
            end else lbs_we = 1'b0;
            @(posedge axis_clk); #1;
        end
        lbs_we = 1'b0;
        checks++;
        if (cnt !== expect_len) begin
            errors++;
            $display("FAIL %s: got %0d clocks expected %0d", name, cnt, expect_len);
        end
    endtask

    task automatic test_led();
        led_run("led_len", 0, LED_LEN);
        led_run("led_retrig", 1, LED_LEN + 500);
        lb_write(BASE + 14'd2, 32'h5554);
        checks++;
        if (led_pulse !== 1'b0) begin
            errors++;
            $display("FAIL led_bad_key: got %b expected 0", led_pulse);
        end
    endtask

    task automatic test_saturation();
        bit acc;
        logic [31:0] rd, exp;
        cycle_rx(4'b1111, 4'b1111, 1, 0, BASE, 0, acc);
        @(negedge axis_clk);
        s_rx_tvalid = '0; lbs_we = 1'b0;
        force dut.rx_pkt_cnt = 32'hFFFF_FFFE;
        model_edge(0, 0, 0, 0, 0, BASE, 0);
        @(negedge axis_clk);
        release dut.rx_pkt_cnt;
        rx_cnt_m = 32'hFFFF_FFFE;
        cycle_rx(4'b1111, 4'b1111, 1, 0, BASE, 0, acc);
        cycle_rx(4'b1111, 4'b1111, 1, 0, BASE, 0, acc);
        lb_read(BASE + 14'd3, rd, exp);
        checks++;
        if (rd !== 32'hFFFF_FFFF || exp !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL rx_saturate: got %h expected %h", rd, 32'hFFFF_FFFF);
        end
        lb_write(BASE + 14'd6, 32'h5555);
        read_check("clr_rx", BASE + 14'd3);
        read_check("clr_tx", BASE + 14'd4);
        cycle_rx(4'b1111, 4'b1111, 1, 0, BASE, 0, acc);
        cycle_rx(4'b1111, 4'b1111, 1, 1, BASE + 14'd6, 32'h5555, acc);
        lb_read(BASE + 14'd3, rd, exp);
        checks++;
        if (rd !== 32'd0 || exp !== 32'd0) begin
            errors++;
            $display("FAIL clr_wins: got %h expected %h", rd, 32'd0);
        end
    endtask

    task automatic test_reset_mid_packet();
        bit acc;
        cycle_rx(4'b0000, 4'b0000, 1, 1, BASE, 1, acc);
        cycle_rx(4'b0010, 4'b0000, 1, 0, BASE, 0, acc);
        cycle_rx(4'b0010, 4'b0000, 1, 0, BASE, 0, acc);
        @(negedge axis_clk);
        rst_n = 1'b0;
        s_rx_tvalid = '0; lbs_we = 1'b0;
        model_reset();
        @(negedge axis_clk);
        rst_n = 1'b1;
        read_check("rst_mid_status", BASE + 14'd5);
        cycle_rx(4'b0011, 4'b0011, 1, 0, BASE, 0, acc);
    endtask

    initial begin
        test_reset();
        test_rx_packets();
        test_rx_switch();
        test_rx_random();
        test_tx();
        test_led();
        test_saturation();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
